// File: rtl/ddr_wr_arbiter.sv
// rtl/ddr_wr_arbiter.sv - two-requester round-robin arbiter for the DDR write-port channel
// Optional watchdog: define DDR_WR_ARB_TIMEOUT_EN to abort a stalled burst after TIMEOUT_CYC idle cycles.
module ddr_wr_arbiter #(
    parameter int  ADDR_WIDTH    = 30,
    parameter int  MEM_DATA_BITS = 256,
    parameter int  TIMEOUT_CYC   = 4096,
    parameter real TCQ           = 0.1
) (
    input  logic                     ddr_clk_i,
    input  logic                     ddr_rst_n_i,
    input  logic                     s0_wr_ddr_req_i,
    input  logic [7:0]               s0_wr_ddr_len_i,
    input  logic [ADDR_WIDTH-1:0]    s0_wr_ddr_addr_i,
    output logic                     s0_ddr_fifo_rd_req_o,
    input  logic [MEM_DATA_BITS-1:0] s0_wr_ddr_data_i,
    output logic                     s0_wr_ddr_finish_o,
    input  logic                     s1_wr_ddr_req_i,
    input  logic [7:0]               s1_wr_ddr_len_i,
    input  logic [ADDR_WIDTH-1:0]    s1_wr_ddr_addr_i,
    output logic                     s1_ddr_fifo_rd_req_o,
    input  logic [MEM_DATA_BITS-1:0] s1_wr_ddr_data_i,
    output logic                     s1_wr_ddr_finish_o,
    output logic                     m_wr_ddr_req_o,
    output logic [7:0]               m_wr_ddr_len_o,
    output logic [ADDR_WIDTH-1:0]    m_wr_ddr_addr_o,
    input  logic                     m_ddr_fifo_rd_req_i,
    output logic [MEM_DATA_BITS-1:0] m_wr_ddr_data_o,
    input  logic                     m_wr_ddr_finish_i,
    output logic [1:0]               arb_grant_o,
    output logic                     arb_len_err_o,
    output logic                     arb_timeout_o
);

    typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_RELEASE} state_t;

    state_t                  r_state;
    state_t                  w_next_state;
    logic [1:0]              r_grant;
    logic                    r_last_grant;
    logic                    r_m_req;
    logic [7:0]              r_len;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [8:0]              r_beat_cnt;
    logic                    r_len_err;

    logic                    w_busy;
    logic                    w_fin;
    logic                    w_beat;
    logic [8:0]              w_beat_next;
    logic                    w_any_req;
    logic                    w_pick_s1;
    logic                    w_timeout;
    logic                    w_end;

    assign w_busy      = (r_state == ST_BUSY);
    assign w_fin       = w_busy & m_wr_ddr_finish_i;
    assign w_beat      = w_busy & m_ddr_fifo_rd_req_i;
    assign w_beat_next = (w_beat && (r_beat_cnt != 9'h1FF)) ? r_beat_cnt + 9'd1 : r_beat_cnt;
    assign w_any_req   = s0_wr_ddr_req_i | s1_wr_ddr_req_i;
    // On a tie, the requester not served last wins; r_last_grant=1 means s1 was last.
    assign w_pick_s1   = s1_wr_ddr_req_i & (~s0_wr_ddr_req_i | ~r_last_grant);

`ifdef DDR_WR_ARB_TIMEOUT_EN
    logic [15:0] r_to_cnt;

    always_ff @(posedge ddr_clk_i or negedge ddr_rst_n_i) begin
        if (!ddr_rst_n_i) begin
            r_to_cnt <= 16'd0;
        end else if (!w_busy || w_beat || m_wr_ddr_finish_i) begin
            r_to_cnt <= 16'd0;
        end else begin
            r_to_cnt <= r_to_cnt + 16'd1;
        end
    end

    assign w_timeout = w_busy & ~m_wr_ddr_finish_i & (r_to_cnt == 16'(TIMEOUT_CYC));
`else
    assign w_timeout = 1'b0;
`endif

    assign w_end = w_fin | w_timeout;

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:    if (w_any_req) w_next_state = ST_BUSY;
            ST_BUSY:    if (w_end)     w_next_state = ST_RELEASE;
            ST_RELEASE: w_next_state = ST_IDLE;
            default:    w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge ddr_clk_i or negedge ddr_rst_n_i) begin
        if (!ddr_rst_n_i) begin
            r_state      <= ST_IDLE;
            r_grant      <= 2'b00;
            r_last_grant <= 1'b1;
            r_m_req      <= 1'b0;
            r_len        <= 8'd0;
            r_addr       <= '0;
            r_beat_cnt   <= 9'd0;
            r_len_err    <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_len_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_any_req) begin
                        r_grant    <= w_pick_s1 ? 2'b10 : 2'b01;
                        r_len      <= w_pick_s1 ? s1_wr_ddr_len_i : s0_wr_ddr_len_i;
                        r_addr     <= w_pick_s1 ? s1_wr_ddr_addr_i : s0_wr_ddr_addr_i;
                        r_m_req    <= 1'b1;
                        r_beat_cnt <= 9'd0;
                    end
                end
                ST_BUSY: begin
                    r_beat_cnt <= w_beat_next;
                    if (w_end) begin
                        r_m_req      <= 1'b0;
                        r_last_grant <= r_grant[1];
                    end
                    // A beat landing in the finish cycle counts towards the total.
                    if (w_fin && (w_beat_next != {1'b0, r_len})) begin
                        r_len_err <= 1'b1;
                    end
                end
                ST_RELEASE: r_grant <= 2'b00;
                default:    r_grant <= 2'b00;
            endcase
        end
    end

    assign s0_ddr_fifo_rd_req_o = w_beat & r_grant[0];
    assign s1_ddr_fifo_rd_req_o = w_beat & r_grant[1];
    assign s0_wr_ddr_finish_o   = w_end & r_grant[0];
    assign s1_wr_ddr_finish_o   = w_end & r_grant[1];
    assign m_wr_ddr_data_o      = r_grant[0] ? s0_wr_ddr_data_i :
                                  r_grant[1] ? s1_wr_ddr_data_i : '0;
    assign m_wr_ddr_req_o       = r_m_req;
    assign m_wr_ddr_len_o       = r_len;
    assign m_wr_ddr_addr_o      = r_addr;
    assign arb_grant_o          = r_grant;
    assign arb_len_err_o        = r_len_err;
    assign arb_timeout_o        = w_timeout;

endmodule

// File: doc/ddr_wr_arbiter.md
# ddr_wr_arbiter

Two-requester round-robin arbiter for the DDR write-port channel (req/len/addr/data/rd_req/finish), running in the DDR user clock domain. It sits between two vin buffer controllers (acc_dump path on s0, FBC path on s1) and the single DDR write master. It grants one requester per burst and routes address, length, data and handshakes to and from it. It holds the grant until the DDR side reports burst completion.

## Interface
- ADDR_WIDTH, 30, DDR write address width
- MEM_DATA_BITS, 256, DDR write data width
- TIMEOUT_CYC, 4096, watchdog limit in cycles (only used with DDR_WR_ARB_TIMEOUT_EN)
- TCQ, 0.1, simulation register delay

Ports:
- ddr_clk_i  in  1  DDR user clock; the block's only clock
- ddr_rst_n_i  in  1  reset, asynchronous and active-low
- sN_wr_ddr_req_i  in  1  requester N write request (N=0,1); held high until its finish
- sN_wr_ddr_len_i  in  8  requester N burst length in beats
- sN_wr_ddr_addr_i  in  ADDR_WIDTH  requester N burst start address
- sN_ddr_fifo_rd_req_o  out  1  data-pop strobe routed to requester N
- sN_wr_ddr_data_i  in  MEM_DATA_BITS  requester N write data
- sN_wr_ddr_finish_o  out  1  burst-done pulse routed to requester N
- m_wr_ddr_req_o  out  1  write request to the DDR master
- m_wr_ddr_len_o  out  8  latched burst length
- m_wr_ddr_addr_o  out  ADDR_WIDTH  latched start address
- m_ddr_fifo_rd_req_i  in  1  data-pop strobe from the DDR master
- m_wr_ddr_data_o  out  MEM_DATA_BITS  muxed write data
- m_wr_ddr_finish_i  in  1  burst-done pulse from the DDR master
- arb_grant_o  out  2  one-hot current grant; 0 when idle
- arb_len_err_o  out  1  one-cycle pulse when the beat count does not match the length at finish
- arb_timeout_o  out  1  one-cycle watchdog pulse (tied 0 without the macro)

## Operation
- FSM states: IDLE, BUSY, RELEASE.
- IDLE:
  - If any sN_req_i is high, pick the winner round-robin. The requester that was not granted last wins a tie. After reset, s0 has priority.
  - Register grant, len and addr. Set m_wr_ddr_req_o=1. Clear the beat counter. Go to BUSY.
- BUSY:
  - m_wr_ddr_req_o, len and addr stay constant.
  - m_ddr_fifo_rd_req_i is routed combinationally to the granted sN_ddr_fifo_rd_req_o only. The other requester sees 0.
  - m_wr_ddr_data_o = data of the granted requester. It is combinational, indexed by the registered grant.
  - Each rd_req beat increments the 9-bit beat counter. The counter saturates at 511.
- On m_wr_ddr_finish_i in BUSY:
  - Route the pulse combinationally to the granted sN_wr_ddr_finish_o.
  - Clear m_wr_ddr_req_o on the next edge.
  - Record last_grant. Go to RELEASE.
  - If beat_cnt (including a beat in the same cycle) is not equal to len, pulse arb_len_err_o on the next cycle.
- RELEASE: lasts one cycle and gives the finished requester time to drop its req. Arbitration is not evaluated. Go to IDLE.
- Boundary behaviour:
  - A requester that drops req during BUSY is ignored; the grant holds until finish.
  - m_wr_ddr_finish_i and m_ddr_fifo_rd_req_i in IDLE or RELEASE are ignored and not routed.
  - If both requests rise in the same cycle, the round-robin pointer decides.
  - A requester that keeps req high after finish is re-granted only if the other is idle.
  - Reset mid-burst clears all outputs and the FSM to IDLE. last_grant resets to 1, so s0 wins first.

## Timing
- Reset values: all outputs 0. arb_grant_o=2'b00.
- Request seen in IDLE at edge t: arb_grant_o and m_wr_ddr_req_o are valid after edge t (one-cycle latency).
- Finish at cycle f: sN_finish_o is high in cycle f. m_wr_ddr_req_o is low from f+1. RELEASE occupies f+1. The earliest next m_wr_ddr_req_o is at f+3.
- rd_req and finish routing have zero latency (combinational). Data mux has zero latency.
- arb_len_err_o and arb_timeout_o pulse for exactly one cycle.

## Configuration
- DDR_WR_ARB_TIMEOUT_EN:
  - When defined, a 16-bit counter runs in BUSY and clears on each rd_req beat or on finish.
  - When the counter reaches TIMEOUT_CYC:
    - Pulse arb_timeout_o.
    - Force m_wr_ddr_req_o=0.
    - Pulse the granted sN_wr_ddr_finish_o for one cycle so the requester unblocks.
    - Go to RELEASE.
  - When not defined, there is no counter and arb_timeout_o=0. BUSY waits indefinitely for finish.

## Test plan
- Reset, then s0 requests with len=128 and addr=0x1000. The master issues 128 rd_req beats, then finish. Required: grant=01, m_addr=0x1000, m_len=128, 128 pops seen only on s0, s0_finish pulse, no len_err.
- s0 and s1 raise req in the same cycle with s0 held high continuously. Required: grant order s0, s1, s0, s1. Next m_req is asserted 3 cycles after each finish.
- s1 is granted with len=128 and only 127 beats are issued before finish. Required: arb_len_err_o pulses once, 1 cycle after finish.
- ddr_rst_n_i is asserted after beat 40 of a burst. Required: all outputs are 0 immediately. After release, s0 wins when both request.
- Stray finish and rd_req in IDLE. Required: no sN_finish_o or sN_rd_req_o pulses, and the FSM stays in IDLE.
- With DDR_WR_ARB_TIMEOUT_EN and TIMEOUT_CYC=64, grant s0 and stall with no beats. Required: arb_timeout_o pulses 64 cycles after the last activity, s0_finish pulses, and m_req drops.
